// File: rtl/dbus_pkg.sv
// dbus_pkg: shared constants for the data-bus responder.
// MMIO byte offsets, CON_STATUS bit positions and the MMIO select bit.
package dbus_pkg;

   localparam logic [7:0] CON_TX     = 8'h00;
   localparam logic [7:0] CON_STATUS = 8'h04;
   localparam logic [7:0] CYCLE_LO   = 8'h08;
   localparam logic [7:0] CYCLE_HI   = 8'h0C;
   localparam logic [7:0] SCRATCH    = 8'h10;

   localparam int EMPTY = 0;
   localparam int FULL  = 1;
   localparam int OVF   = 2;

   localparam int MMIO_SEL_BIT = 31;

   // Word-aligned MMIO byte offset: daddr[7:2] with the low two bits forced to zero.
   function automatic logic [7:0] mmio_offset(input logic [31:0] addr);
      return {addr[7:2], 2'b00};
   endfunction

endpackage

// File: rtl/dbus_con_fifo.sv
// dbus_con_fifo: console transmit FIFO (bytes), synchronous active-high reset.
// A push while full is accepted only if a pop happens in the same cycle;
// otherwise the byte is dropped and 'dropped' pulses for that cycle.
// A pop request while empty is ignored, so push+pop on empty leaves count = 1.
module dbus_con_fifo
   import dbus_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [7:0]               push_data,
   input  logic                     pop,
   output logic [7:0]               head_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     dropped
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [7:0]    mem_r [DEPTH];
   logic [PW-1:0] rd_ptr_r;
   logic [PW-1:0] wr_ptr_r;
   logic [CW-1:0] count_r;
   logic          pop_s;
   logic          push_ok_s;

   // Qualify pop with non-empty and push with room (or a same-cycle pop).
   always_comb begin
      pop_s     = pop & (count_r != CW'(0));
      push_ok_s = push & ((count_r < CW'(DEPTH)) | pop_s);
      dropped   = push & ~push_ok_s;
   end

   // Pointer and occupancy update; power-of-two depth lets the pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_r <= PW'(0);
         wr_ptr_r <= PW'(0);
         count_r  <= CW'(0);
      end else begin
         if (pop_s)     rd_ptr_r <= rd_ptr_r + PW'(1);
         if (push_ok_s) wr_ptr_r <= wr_ptr_r + PW'(1);
         case ({push_ok_s, pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Storage write; contents need no reset because pointers define validity.
   always_ff @(posedge clk) begin
      if (push_ok_s && !reset) mem_r[wr_ptr_r] <= push_data;
   end

   assign head_data = mem_r[rd_ptr_r];
   assign full      = (count_r == CW'(DEPTH));
   assign empty     = (count_r == CW'(0));
   assign count     = count_r;

endmodule

// File: rtl/dbus_responder.sv
// dbus_responder: single-cycle data-bus responder (RAM + MMIO console/scratch/cycle counter).
// Read data is combinational from daddr; all writes commit on the rising edge when reset = 0.
// Optional macro DBUS_CYCLE_CTR_EN builds the 64-bit cycle counter; without it
// CYCLE_LO/CYCLE_HI read 0 and no counter flops exist.
module dbus_responder
   import dbus_pkg::*;
#(
   parameter int DMEM_WORDS = 1024,
   parameter int CON_DEPTH  = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] daddr,
   input  logic [31:0] dwdata,
   input  logic [3:0]  dwe,
   output logic [31:0] drdata,
   output logic [7:0]  con_data,
   output logic        con_valid,
   input  logic        con_ready
);

   localparam int AW = $clog2(DMEM_WORDS);
   localparam int CW = $clog2(CON_DEPTH) + 1;

   logic [31:0]   ram_r [DMEM_WORDS];
   logic [31:0]   scratch_r;
   logic          ovf_r;
   logic [63:0]   cycle_s;

   logic          mmio_sel_s;
   logic [7:0]    off_s;
   logic [AW-1:0] ram_idx_s;
   logic          wr_en_s;
   logic          ram_we_s;
   logic          scratch_we_s;
   logic          con_push_s;
   logic          ovf_clr_s;
   logic          fifo_full_s;
   logic          fifo_empty_s;
   logic          fifo_dropped_s;
   logic [CW-1:0] fifo_count_s;
   logic [31:0]   rdata_s;
   logic          unused_s;

   assign mmio_sel_s = daddr[MMIO_SEL_BIT];
   assign off_s      = mmio_offset(daddr);
   assign ram_idx_s  = daddr[AW+1:2];
   assign unused_s   = ^{daddr[30:8], daddr[1:0]};

   // Write strobes per target; reset suppresses every write.
   always_comb begin
      wr_en_s      = (dwe != 4'b0000) & ~reset;
      ram_we_s     = wr_en_s & ~mmio_sel_s;
      scratch_we_s = wr_en_s & mmio_sel_s & (off_s == SCRATCH);
      con_push_s   = wr_en_s & mmio_sel_s & (off_s == CON_TX) & dwe[0];
      ovf_clr_s    = wr_en_s & mmio_sel_s & (off_s == CON_STATUS) & dwe[0] & dwdata[OVF];
   end

   dbus_con_fifo #(
      .DEPTH(CON_DEPTH)
   ) u_con_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (con_push_s),
      .push_data (dwdata[7:0]),
      .pop       (con_ready),
      .head_data (con_data),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s),
      .count     (fifo_count_s),
      .dropped   (fifo_dropped_s)
   );

   assign con_valid = (fifo_count_s != CW'(0));

   // Byte-enabled RAM write; contents survive reset.
   always_ff @(posedge clk) begin
      if (ram_we_s) begin
         for (int i = 0; i < 4; i++) begin
            if (dwe[i]) ram_r[ram_idx_s][8*i +: 8] <= dwdata[8*i +: 8];
         end
      end
   end

   // Byte-enabled scratch register.
   always_ff @(posedge clk) begin
      if (reset) begin
         scratch_r <= 32'h0000_0000;
      end else if (scratch_we_s) begin
         for (int i = 0; i < 4; i++) begin
            if (dwe[i]) scratch_r[8*i +: 8] <= dwdata[8*i +: 8];
         end
      end
   end

   // Sticky console overflow flag; a new overflow beats a same-cycle clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         ovf_r <= 1'b0;
      end else if (fifo_dropped_s) begin
         ovf_r <= 1'b1;
      end else if (ovf_clr_s) begin
         ovf_r <= 1'b0;
      end
   end

`ifdef DBUS_CYCLE_CTR_EN
   logic [63:0] cycle_r;

   // Free-running cycle counter, wraps from all-ones to zero.
   always_ff @(posedge clk) begin
      if (reset) cycle_r <= 64'd0;
      else       cycle_r <= cycle_r + 64'd1;
   end

   assign cycle_s = cycle_r;
`else
   assign cycle_s = 64'd0;
`endif

   // Combinational read mux: MMIO register file or RAM word.
   always_comb begin
      rdata_s = 32'h0000_0000;
      if (mmio_sel_s) begin
         case (off_s)
            CON_TX:     rdata_s = 32'h0000_0000;
            CON_STATUS: rdata_s = {29'd0, ovf_r, fifo_full_s, fifo_empty_s};
            CYCLE_LO:   rdata_s = cycle_s[31:0];
            CYCLE_HI:   rdata_s = cycle_s[63:32];
            SCRATCH:    rdata_s = scratch_r;
            default:    rdata_s = 32'h0000_0000;
         endcase
      end else begin
         rdata_s = ram_r[ram_idx_s];
      end
   end

   assign drdata = rdata_s;

endmodule

// File: tb/tb_dbus_responder.sv
// tb_dbus_responder: directed stimulus with a behavioural reference model
// (byte map for RAM, queue for the console FIFO) checked every cycle at negedge,
// plus literal expectations for the documented scenarios.
`timescale 1ns/1ps
module tb_dbus_responder;

   localparam int DMEM_WORDS = 1024;
   localparam int CON_DEPTH  = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] daddr = 32'h0;
   logic [31:0] dwdata = 32'h0;
   logic [3:0]  dwe = 4'h0;
   logic [31:0] drdata;
   logic [7:0]  con_data;
   logic        con_valid;
   logic        con_ready = 1'b0;

   int checks = 0;
   int errors = 0;

   dbus_responder #(.DMEM_WORDS(DMEM_WORDS), .CON_DEPTH(CON_DEPTH)) dut (
      .clk(clk), .reset(reset), .daddr(daddr), .dwdata(dwdata), .dwe(dwe),
      .drdata(drdata), .con_data(con_data), .con_valid(con_valid), .con_ready(con_ready)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [7:0]  ram_m [int];
   logic [7:0]  con_q [$];
   logic [31:0] scratch_m;
   logic        ovf_m;
   logic [63:0] cyc_m;
   bit          started_m = 0;
   logic [7:0]  drained [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int ram_base(input logic [31:0] a);
      return int'((a[30:0] >> 2) % DMEM_WORDS) * 4;
   endfunction

   function automatic void model_read(input logic [31:0] a, output logic [31:0] v, output bit known);
      int off;
      int base;
      v = 32'h0;
      known = 1;
      if (a[31]) begin
         off = int'(a[7:0]) & 'hFC;
         if (off == 'h04) v = {29'd0, ovf_m, (con_q.size() == CON_DEPTH), (con_q.size() == 0)};
`ifdef DBUS_CYCLE_CTR_EN
         else if (off == 'h08) v = cyc_m[31:0];
         else if (off == 'h0C) v = cyc_m[63:32];
`endif
         else if (off == 'h10) v = scratch_m;
         else v = 32'h0;
      end else begin
         base = ram_base(a);
         for (int l = 0; l < 4; l++) begin
            if (ram_m.exists(base + l)) v[8*l +: 8] = ram_m[base + l];
            else known = 0;
         end
      end
   endfunction

   // Model state advance on each rising edge, using the inputs presented in that cycle.
   always @(posedge clk) begin
      int  old;
      bit  pop_m;
      bit  drop_m;
      bit  mm;
      int  off;
      if (reset) begin
         con_q.delete();
         ovf_m = 1'b0;
         scratch_m = 32'h0;
         cyc_m = 64'd0;
         started_m = 1;
      end else begin
         if (con_valid && con_ready) drained.push_back(con_data);
         cyc_m = cyc_m + 64'd1;
         old = con_q.size();
         pop_m = (old != 0) && con_ready;
         drop_m = 0;
         mm = daddr[31];
         off = int'(daddr[7:0]) & 'hFC;
         if (pop_m) void'(con_q.pop_front());
         if (mm && off == 'h00 && dwe[0]) begin
            if (old < CON_DEPTH || pop_m) con_q.push_back(dwdata[7:0]);
            else drop_m = 1;
         end
         if (mm && off == 'h04 && dwe[0] && dwdata[2]) ovf_m = 1'b0;
         if (drop_m) ovf_m = 1'b1;
         for (int l = 0; l < 4; l++) begin
            if (dwe[l]) begin
               if (!mm) ram_m[ram_base(daddr) + l] = dwdata[8*l +: 8];
               else if (off == 'h10) scratch_m[8*l +: 8] = dwdata[8*l +: 8];
            end
         end
      end
   end

   // Per-cycle comparison of DUT outputs against the model.
   always @(negedge clk) begin
      logic [31:0] ev;
      bit          kn;
      if (started_m && !reset) begin
         model_read(daddr, ev, kn);
         if (kn) check("drdata_model", drdata, ev);
         check("con_valid_model", con_valid, (con_q.size() != 0));
         if (con_q.size() != 0) check("con_data_model", con_data, con_q[0]);
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
      @(negedge clk);
      #1;
      daddr = a;
      dwdata = d;
      dwe = we;
   endtask

   task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
      drive(a, 32'h0, 4'h0);
      #1;
      check(name, drdata, exp);
   endtask

   localparam logic [31:0] A_TX   = 32'h8000_0000;
   localparam logic [31:0] A_STAT = 32'h8000_0004;
   localparam logic [31:0] A_CLO  = 32'h8000_0008;
   localparam logic [31:0] A_CHI  = 32'h8000_000C;
   localparam logic [31:0] A_SCR  = 32'h8000_0010;

   initial begin
      repeat (2) @(negedge clk);
      #1 reset = 1'b0;

      // RAM byte lanes and aliasing
      drive(32'h0000_0100, 32'h1122_3344, 4'b1111);
      drive(32'h0000_0100, 32'hAAAA_AAAA, 4'b0100);
      rd("ram_lane2", 32'h0000_0100, 32'h11AA_3344);
      rd("ram_alias", 32'h0000_0100 + 32'(4 * DMEM_WORDS), 32'h11AA_3344);
      rd("cycle_hi_zero", A_CHI, 32'h0);
      rd("unmapped_rd", 32'h8000_0040, 32'h0);

      // Console FIFO drain
      drive(A_TX, 32'h41, 4'b0001);
      drive(A_TX, 32'h42, 4'b0001);
      drive(A_TX, 32'h43, 4'b0001);
      rd("tx_reads_zero", A_TX, 32'h0);
      rd("status_3queued", A_STAT, 32'h0);
      drained.delete();
      @(negedge clk); #1 con_ready = 1'b1;
      repeat (4) @(negedge clk);
      #1 con_ready = 1'b0;
      check("drain_count", drained.size(), 3);
      if (drained.size() == 3) begin
         check("drain_0", drained[0], 8'h41);
         check("drain_1", drained[1], 8'h42);
         check("drain_2", drained[2], 8'h43);
      end
      check("drain_valid_low", con_valid, 1'b0);
      #1 check("status_empty", drdata, 32'h1);

      // Overflow: CON_DEPTH+1 pushes
      for (int i = 0; i <= CON_DEPTH; i++) drive(A_TX, 32'h60 + 32'(i), 4'b0001);
      rd("status_ovf_full", A_STAT, 32'h6);
      drained.delete();
      @(negedge clk); #1 con_ready = 1'b1;
      repeat (CON_DEPTH + 2) @(negedge clk);
      #1 con_ready = 1'b0;
      check("ovf_drain_count", drained.size(), CON_DEPTH);
      for (int i = 0; i < drained.size(); i++) check("ovf_drain_byte", drained[i], 8'h60 + 8'(i));
      #1 check("status_ovf_empty", drdata, 32'h5);
      drive(A_STAT, 32'h4, 4'b0001);
      rd("status_ovf_cleared", A_STAT, 32'h1);

      // Full FIFO with simultaneous push and pop
      for (int i = 0; i < CON_DEPTH; i++) drive(A_TX, 32'h70 + 32'(i), 4'b0001);
      drained.delete();
      @(negedge clk); #1;
      daddr = A_TX; dwdata = 32'h5A; dwe = 4'b0001; con_ready = 1'b1;
      @(negedge clk); #1;
      daddr = A_STAT; dwe = 4'b0000; con_ready = 1'b0;
      #1 check("status_still_full", drdata, 32'h2);
      @(negedge clk); #1 con_ready = 1'b1;
      repeat (CON_DEPTH + 2) @(negedge clk);
      #1 con_ready = 1'b0;
      check("full_pp_count", drained.size(), CON_DEPTH + 1);
      if (drained.size() == CON_DEPTH + 1) begin
         check("full_pp_first", drained[0], 8'h70);
         check("full_pp_last", drained[CON_DEPTH], 8'h5A);
      end

      // Scratch byte enables
      drive(A_SCR, 32'hDEAD_BEEF, 4'b1111);
      drive(A_SCR, 32'h0000_0000, 4'b0010);
      rd("scratch_lane1", A_SCR, 32'hDEAD_00EF);

      // Reset with a store presented in the same cycle
      drive(A_TX, 32'h99, 4'b0001);
      @(negedge clk); #1;
      reset = 1'b1; daddr = A_SCR; dwdata = 32'h1234_5678; dwe = 4'b1111;
      @(negedge clk); #1;
      reset = 1'b0; daddr = A_CLO; dwe = 4'b0000;
      #1 check("cycle_lo_after_reset", drdata, 32'h0);
      check("fifo_empty_after_reset", con_valid, 1'b0);
      repeat (20) @(negedge clk);
      #2;
`ifdef DBUS_CYCLE_CTR_EN
      check("cycle_lo_n", drdata, 32'd20);
`else
      check("cycle_lo_n", drdata, 32'd0);
`endif
      rd("scratch_after_reset", A_SCR, 32'h0);
      rd("status_after_reset", A_STAT, 32'h1);

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dbus_responder.md
Name: dbus_responder

Overview:
- Data-side bus responder that sits on the CPU's single-cycle data port (daddr/dwdata/dwe/drdata). Turns CPU loads and stores into RAM accesses and memory-mapped peripheral accesses.
- Provides byte-enabled data RAM, a console transmit FIFO with a valid/ready output stream, a scratch register and a free-running 64-bit cycle counter.
- Read data is combinational so the CPU completes a load in one cycle; all state updates on the rising clock edge.

Parameters:
- DMEM_WORDS, 1024, number of 32-bit RAM words; power of two.
- CON_DEPTH, 8, console FIFO depth in bytes; power of two, at least 2.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- daddr  input  32  byte address from CPU
- dwdata  input  32  store data, already lane-replicated by CPU
- dwe  input  4  per-byte write enables; 0000 = no write
- drdata  output  32  read data, combinational from daddr
- con_data  output  8  console byte at FIFO head
- con_valid  output  1  FIFO non-empty
- con_ready  input  1  downstream consumer accepts con_data

Behaviour:
- Address decode:
  - daddr[31]=0 selects RAM. Word index = daddr[log2(DMEM_WORDS)+1:2]; higher bits are ignored, so addresses alias (wrap).
  - daddr[31]=1 selects MMIO. Register offset = daddr[7:2]; daddr[30:8] and daddr[1:0] are ignored.
- MMIO map (byte offsets):
  - 0x00 CON_TX: write with dwe[0]=1 pushes dwdata[7:0]. Reads as 0.
  - 0x04 CON_STATUS: read {29'b0, ovf, full, empty}. A write with dwe[0]=1 and dwdata[2]=1 clears ovf.
  - 0x08 CYCLE_LO, 0x0C CYCLE_HI: read-only.
  - 0x10 SCRATCH: read/write, byte-enabled per dwe lane.
  - All other offsets read 0; writes to them are ignored.
- Reads:
  - drdata is purely combinational from daddr and current state, with no registered latency.
  - A read of an address written in the same cycle returns the old value.
- Writes:
  - Committed at posedge when dwe != 0 and reset = 0.
  - Each lane i writes byte i only when dwe[i] = 1, to RAM or SCRATCH.
  - Any dwe pattern is honoured as given; the responder does no alignment checking.
- Reset (synchronous):
  - FIFO read/write pointers and count go to 0; con_valid = 0; ovf = 0; SCRATCH = 0; cycle counter = 0.
  - RAM contents are not reset.
  - All writes are ignored while reset = 1, including a write presented in the same cycle reset asserts.
  - Reset asserted mid-stream discards queued console bytes.
- Console FIFO:
  - con_valid = (count != 0).
  - con_data = mem[rd_ptr], held stable while con_valid = 1 and con_ready = 0.
  - Pop happens when con_valid & con_ready.
  - Push happens when a CON_TX write occurs and either count < CON_DEPTH or a pop occurs in the same cycle. A simultaneous push and pop while full is accepted and count stays at CON_DEPTH.
  - A push while full with no pop drops the byte and sets sticky ovf.
  - Simultaneous push and pop while empty: push is accepted, no pop occurs, count becomes 1.
  - Pointers wrap modulo CON_DEPTH.
  - A clear of ovf in the same cycle as a new overflow leaves ovf = 1 (set wins).
- Cycle counter: 64-bit, increments by 1 every cycle when reset = 0, and wraps from all-ones to 0. LO and HI are read independently with no snapshotting.

Optional Feature:
- Macro DBUS_CYCLE_CTR_EN.
- Defined: the cycle counter exists as specified.
- Undefined: no counter flops are built, CYCLE_LO and CYCLE_HI read 0, and writes to them are still ignored.

Decomposition:
- Package dbus_pkg holds:
  - MMIO offset constants: CON_TX, CON_STATUS, CYCLE_LO, CYCLE_HI, SCRATCH.
  - Status bit positions: EMPTY=0, FULL=1, OVF=2.
  - The MMIO select bit index (31).
- One sub-module, dbus_con_fifo: synchronous FIFO with push, pop, full, empty and count outputs. It follows the full/empty and simultaneous push/pop rules above.
- RAM and decode stay in dbus_responder.

Test Plan:
- RAM byte lanes:
  - Write 0x11223344 to 0x100 with dwe=1111; then write dwdata=0xAAAAAAAA with dwe=0100; then read 0x100 → 0x11AA3344.
  - Read 0x100 + 4×DMEM_WORDS → same value (aliasing).
- Console FIFO drain:
  - With con_ready=0, write 0x41, 0x42, 0x43 to 0x80000000 → CON_STATUS reads 0.
  - Raise con_ready → con_data presents 0x41, 0x42, 0x43 on consecutive cycles, then con_valid=0 and CON_STATUS reads 1.
- Console FIFO overflow:
  - With con_ready=0, push CON_DEPTH+1 bytes → CON_STATUS reads 0b110 and the last byte is absent from the drain.
  - Write 0x4 to 0x80000004 → ovf clears.
- Full push/pop:
  - Fill the FIFO, then present con_ready=1 and a push of 0x5A in the same cycle → count remains CON_DEPTH and 0x5A drains last.
- Reset behaviour:
  - Assert reset for 1 cycle while a store is presented to SCRATCH with dwe=1111 → SCRATCH reads 0, FIFO is empty and CYCLE_LO reads 0.
  - After N non-reset cycles, CYCLE_LO reads N with DBUS_CYCLE_CTR_EN defined, and reads 0 without it.
